// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and step-counter sizing.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

  // Counter must hold WIDTH itself, hence WIDTH+1 distinct values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/Busy/Done handshake and operand/result bus of the divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, Dividend, Divisor,
    input  Quotient, Remainder, Busy, Done, DivByZero
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Quotient, Remainder, Busy, Done, DivByZero
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] trial;
  logic           fits;

  // The partial remainder stays below the divisor, so the post-subtract
  // value always fits in WIDTH bits and modular subtraction is exact.
  always_comb begin
    trial = {r_i, q_i[WIDTH-1]};
    fits  = (trial >= {1'b0, d_i});
    r_o   = fits ? (trial[WIDTH-1:0] - d_i) : trial[WIDTH-1:0];
    q_o   = {q_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with Start/Busy/Done handshake.
// One quotient bit per clock; divide-by-zero completes in a single cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         Clock,
  input  logic         Reset_b,
  seq_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] d_q,     d_d;
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             dbz_q,   dbz_d;

  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_step),
    .q_o (q_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          if (bus.Divisor != '0) begin
            state_d = ST_RUN;
            q_d     = bus.Dividend;
            r_d     = '0;
            d_d     = bus.Divisor;
            cnt_d   = CNT_W'(WIDTH);
          end else begin
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = bus.Dividend;
            dbz_d   = 1'b1;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q - CNT_W'(1);
        // Results are published only on the final step, never mid-run.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          quot_d  = q_step;
          rem_d   = r_step;
          dbz_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rem_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Busy      = (state_q == ST_RUN);
  assign bus.Done      = (state_q == ST_DONE);

endmodule
